// File: rtl/ledstrip_pkg.sv
// Shared definitions for the one-wire LED strip driver: FSM state codes,
// colour-order selectors, time-to-cycle conversion, clog2 and byte helpers.
package ledstrip_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  // Wire byte order selectors
  localparam int ORDER_GRB = 0;
  localparam int ORDER_RGB = 1;
  localparam int ORDER_BRG = 2;

  // Nanoseconds to clock cycles, truncating; 64-bit math keeps products safe
  function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
    return int'((clk_hz / 64'd1000) * ns / 64'd1000000);
  endfunction

  // Microseconds to clock cycles
  function automatic int us_to_cyc(input longint clk_hz, input longint us);
    return int'((clk_hz / 64'd1000000) * us);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Reorder a {R,G,B,W} word into wire order, first byte in the MSBs
  function automatic logic [31:0] reorder(input logic [31:0] rgbw, input int order);
    logic [7:0] r, g, b, w;
    {r, g, b, w} = rgbw;
    case (order)
      ORDER_RGB: return {r, g, b, w};
      ORDER_BRG: return {b, r, g, w};
      default:   return {g, r, b, w};
    endcase
  endfunction

  // byte*(br+1)>>8 so that br=255 passes the byte through unchanged
  function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
    logic [15:0] p;
    p = {8'd0, b} * ({8'd0, br} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/ledstrip_tx_bit_encoder.sv
// One-bit waveform generator: a strobe starts a bit period, the line is high
// for T1H or T0H cycles then low until TBIT cycles have elapsed; done marks the
// last cycle of the period so the next strobe can follow back-to-back.
module ledstrip_bit_encoder
  import ledstrip_pkg::*;
#(
  parameter int T0H_CYC  = 35,
  parameter int T1H_CYC  = 70,
  parameter int TBIT_CYC = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic bit_val,
  output logic line,
  output logic done
);

  localparam int CW = clog2(TBIT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] H0   = CW'(T0H_CYC);
  localparam logic [CW-1:0] H1   = CW'(T1H_CYC);

  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_len;

  // Period counter: restart on strobe, stop after the final cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      hi_len <= '0;
    end else if (strobe) begin
      active <= 1'b1;
      cnt    <= '0;
      hi_len <= bit_val ? H1 : H0;
    end else if (active) begin
      if (cnt == LAST) active <= 1'b0;
      else             cnt    <= cnt + CW'(1);
    end
  end

  // Line and done come straight from registers so reset drops the line at once
  assign line = active && (cnt < hi_len);
  assign done = active && (cnt == LAST);

endmodule

// File: rtl/ledstrip_tx.sv
// WS2812/SK6812 serial driver: fetches pixels over valid/ready into a one-pixel
// holding register, serialises CHANNELS bytes per LED MSB first in the selected
// colour order, then holds DO low for the latch gap.
// Optional feature: define LEDSTRIP_BRIGHTNESS_EN to add a brightness[7:0]
// input that scales every byte at shifter load.
module ledstrip_tx
  import ledstrip_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 100_000_000,
  parameter int CHANNELS     = 3,
  parameter int ORDER        = 0,
  parameter int T0H_NS       = 350,
  parameter int T1H_NS       = 700,
  parameter int TBIT_NS      = 1250,
  parameter int RESET_US     = 80,
  localparam int AW          = (NUM_LEDS > 1) ? clog2(NUM_LEDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [8*CHANNELS-1:0] pix_data,
  output logic [AW-1:0]         address,
  output logic                  frame_done,
  output logic                  underrun,
`ifdef LEDSTRIP_BRIGHTNESS_EN
  input  logic [7:0]            brightness,
`endif
  output logic                  DO
);

  localparam int T0H_CYC  = ns_to_cyc(SYSTEM_CLOCK, T0H_NS);
  localparam int T1H_CYC  = ns_to_cyc(SYSTEM_CLOCK, T1H_NS);
  localparam int TBIT_CYC = ns_to_cyc(SYSTEM_CLOCK, TBIT_NS);
  localparam int RST_CYC  = us_to_cyc(SYSTEM_CLOCK, RESET_US);
  localparam int NB       = 8 * CHANNELS;
  localparam int BW       = clog2(NB);
  localparam int CNTW     = AW + 1;
  localparam int RW       = clog2(RST_CYC + 1);

  localparam logic [BW-1:0]   LAST_BIT = BW'(NB - 1);
  localparam logic [CNTW-1:0] NL       = CNTW'(NUM_LEDS);
  localparam logic [RW-1:0]   RLAST    = RW'(RST_CYC - 1);

  logic [2:0]      state;
  logic            hold_full;
  logic [NB-1:0]   hold_data;
  logic [31:0]     shifter;
  logic [BW-1:0]   bit_idx;
  logic [CNTW-1:0] fetch_cnt;
  logic [CNTW-1:0] led_cnt;
  logic [RW-1:0]   latch_cnt;

  logic        enc_line, enc_done, enc_strobe, enc_bit;
  logic        in_bit, pix_end, more_leds, load, next_bit;
  logic [31:0] raw_word, ordered_word, load_word;

  assign busy       = (state != ST_IDLE);
  assign pix_ready  = busy && !hold_full && (fetch_cnt < NL);
  assign address    = (fetch_cnt < NL) ? fetch_cnt[AW-1:0] : AW'(NUM_LEDS - 1);
  assign frame_done = (state == ST_LATCH) && (latch_cnt == RLAST);
  assign DO         = enc_line;

  // Pixel word aligned to the MSBs (W slot zero for RGB), then reordered
  assign raw_word     = 32'(hold_data) << (32 - NB);
  assign ordered_word = reorder(raw_word, ORDER);

`ifdef LEDSTRIP_BRIGHTNESS_EN
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_scale
    assign load_word[gi*8 +: 8] = scale_byte(ordered_word[gi*8 +: 8], brightness);
  end
`else
  assign load_word = ordered_word;
`endif

  assign in_bit     = (state == ST_HIGH) || (state == ST_LOW);
  assign pix_end    = enc_done && (bit_idx == LAST_BIT);
  assign more_leds  = (led_cnt < NL);
  assign next_bit   = in_bit && enc_done && !pix_end;
  // Load the shifter from FETCH, or straight from the last bit when the next pixel is waiting
  assign load       = hold_full && ((state == ST_FETCH) || (in_bit && pix_end && more_leds));
  assign enc_strobe = load || next_bit;
  assign enc_bit    = load ? load_word[31] : shifter[30];

  ledstrip_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_enc (
    .clk    (clk),
    .rst    (reset),
    .strobe (enc_strobe),
    .bit_val(enc_bit),
    .line   (enc_line),
    .done   (enc_done)
  );

  // Holding register and frame sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      fetch_cnt <= '0;
      latch_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      if (pix_valid && pix_ready) begin
        hold_full <= 1'b1;
        hold_data <= pix_data;
        fetch_cnt <= fetch_cnt + CNTW'(1);
      end else if (load) begin
        hold_full <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            fetch_cnt <= '0;
            underrun  <= 1'b0;
            hold_full <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (load) state <= ST_HIGH;
        end
        ST_HIGH, ST_LOW: begin
          if (enc_done) begin
            if (!pix_end || (more_leds && hold_full)) begin
              state <= ST_HIGH;
            end else if (more_leds) begin
              state    <= ST_FETCH;
              underrun <= 1'b1;
            end else begin
              state     <= ST_LATCH;
              latch_cnt <= '0;
            end
          end else if (!enc_line) begin
            state <= ST_LOW;
          end
        end
        ST_LATCH: begin
          if (latch_cnt == RLAST) state     <= ST_IDLE;
          else                    latch_cnt <= latch_cnt + RW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift register, bit index and LED count for the pixel on the wire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter <= '0;
      bit_idx <= '0;
      led_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      led_cnt <= '0;
    end else if (load) begin
      shifter <= load_word;
      bit_idx <= '0;
      led_cnt <= led_cnt + CNTW'(1);
    end else if (next_bit) begin
      shifter <= shifter << 1;
      bit_idx <= bit_idx + BW'(1);
    end
  end

endmodule

// File: tb/tb_ledstrip_tx.sv
// Self-checking bench for ledstrip_tx: three instances (4 LED RGB GRB order,
// 1 LED RGBW RGB order, 1 LED RGBW BRG order) share clock, reset and start.
// A line decoder measures DO pulse widths and recovers the bit stream, which
// is compared with the stream expected from the pixel data.
module tb_ledstrip_tx;

  localparam int T0 = 35, T1 = 70, TB = 125;
  localparam int RSTA = 1000, RSTB = 8000, RSTC = 200;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic busy_a, ready_a, valid_a, fd_a, ur_a, do_a;
  logic busy_b, ready_b, fd_b, ur_b, do_b;
  logic busy_c, ready_c, fd_c, ur_c, do_c;
  logic [23:0] data_a;
  logic [31:0] data_b, data_c;
  logic [1:0]  addr_a;
  logic [0:0]  addr_b, addr_c;

  ledstrip_tx #(.NUM_LEDS(4), .CHANNELS(3), .ORDER(0), .RESET_US(10)) dut_a (
    .clk(clk), .reset(rst), .start(start), .busy(busy_a), .pix_valid(valid_a),
    .pix_ready(ready_a), .pix_data(data_a), .address(addr_a), .frame_done(fd_a),
    .underrun(ur_a),
`ifdef LEDSTRIP_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .DO(do_a));

  ledstrip_tx #(.NUM_LEDS(1), .CHANNELS(4), .ORDER(1), .RESET_US(80)) dut_b (
    .clk(clk), .reset(rst), .start(start), .busy(busy_b), .pix_valid(1'b1),
    .pix_ready(ready_b), .pix_data(data_b), .address(addr_b), .frame_done(fd_b),
    .underrun(ur_b),
`ifdef LEDSTRIP_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .DO(do_b));

  ledstrip_tx #(.NUM_LEDS(1), .CHANNELS(4), .ORDER(2), .RESET_US(2)) dut_c (
    .clk(clk), .reset(rst), .start(start), .busy(busy_c), .pix_valid(1'b1),
    .pix_ready(ready_c), .pix_data(data_c), .address(addr_c), .frame_done(fd_c),
    .underrun(ur_c),
`ifdef LEDSTRIP_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .DO(do_c));

  int total = 0, bad = 0;

  // ---------------- line decoder, one slot per instance ----------------
  logic [2:0] do_v, fd_v;
  assign do_v = {do_c, do_b, do_a};
  assign fd_v = {fd_c, fd_b, fd_a};

  int hi[3], lo[3], inb[3], nbits[3], hi_err[3], per_err[3], gaps[3], last_total[3], ndone[3];
  bit bits_mem [3][256];
  int addr_bad = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        hi[k] = 0; lo[k] = 0; inb[k] = 0;
      end else begin
        if (do_v[k]) begin
          if (lo[k] > 0 && inb[k] != 0) begin
            if (hi[k] + lo[k] > TB) gaps[k]++;
            else if (hi[k] + lo[k] < TB) per_err[k]++;
            hi[k] = 0; lo[k] = 0;
          end
          hi[k]++; inb[k] = 1;
        end else begin
          if (hi[k] > 0 && lo[k] == 0) begin
            if (hi[k] != T0 && hi[k] != T1) hi_err[k]++;
            if (nbits[k] < 256) bits_mem[k][nbits[k]] = (hi[k] == T1);
            nbits[k]++;
          end
          if (inb[k] != 0) lo[k]++;
        end
        if (fd_v[k]) begin
          last_total[k] = hi[k] + lo[k];
          ndone[k]++;
          inb[k] = 0; hi[k] = 0; lo[k] = 0;
        end
      end
    end
    if (!rst && (addr_b != 1'b0 || addr_c != 1'b0)) addr_bad++;
  end

  // ---------------- pixel source for instance A ----------------
  logic [23:0] pix_a [4];
  logic withhold = 1'b0, released = 1'b0;
  int addr_log [8];
  int nlog = 0;

  always @(negedge clk) begin
    if (rst) begin
      valid_a = 1'b0;
      data_a  = '0;
    end else begin
      valid_a = !(withhold && !released && addr_a == 2'd2);
      data_a  = pix_a[addr_a];
      if (valid_a && ready_a) begin
        if (nlog < 8) addr_log[nlog] = int'(addr_a);
        nlog++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic clear_mon;
    for (int k = 0; k < 3; k++) begin
      nbits[k] = 0; hi_err[k] = 0; per_err[k] = 0; gaps[k] = 0; ndone[k] = 0; last_total[k] = 0;
    end
    nlog = 0;
  endtask

  // Wire byte sequence for a {R,G,B,W} pixel under each colour order
  function automatic logic [31:0] wire_word(input logic [31:0] p, input int order);
    case (order)
      1:       return p;
      2:       return {p[15:8], p[31:24], p[23:16], p[7:0]};
      default: return {p[23:16], p[31:24], p[15:8], p[7:0]};
    endcase
  endfunction

  logic [31:0] exp_px [4];

  // Compare decoded stream of instance k with the expected pixels in exp_px
  task automatic check_stream(input int k, input int nled, input int chans, input int order,
                              input int rst_cyc, input string tag);
    int mism;
    logic [31:0] w;
    mism = 0;
    for (int i = 0; i < nled; i++) begin
      w = wire_word(exp_px[i], order);
      for (int j = 0; j < chans * 8; j++) begin
        int idx;
        idx = i * chans * 8 + j;
        if (idx < nbits[k] && idx < 256 && bits_mem[k][idx] !== w[31-j]) mism++;
      end
    end
    chk({tag, "_nbits"}, nbits[k], nled * chans * 8);
    chk({tag, "_bits"}, mism, 0);
    chk({tag, "_high_width"}, hi_err[k], 0);
    chk({tag, "_period"}, per_err[k], 0);
    chk({tag, "_latch"}, last_total[k], TB + rst_cyc);
    chk({tag, "_done_cnt"}, ndone[k], 1);
    $display("frame %s: bits=%0d done=%0d gaps=%0d", tag, nbits[k], ndone[k], gaps[k]);
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int n;
    n = 0;
    while (!fd_a && n < budget) begin step; n++; end
    chk({tag, "_done_timeout"}, fd_a, 1);
  endtask

  task automatic wait_idle_b(input int budget);
    int n;
    n = 0;
    while (busy_b && n < budget) begin step; n++; end
    chk("b_idle_timeout", busy_b, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, highs;
    rst = 1'b1; start = 1'b0;
    data_b = 32'h01020304; data_c = 32'h01020304;
    for (int i = 0; i < 4; i++) pix_a[i] = 24'($urandom);
    clear_mon();
    repeat (3) step;
    chk("rst_do", do_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_underrun", ur_a, 0);
    rst = 1'b0;
    step;

    // Frame 1: directed pixel 0, continuous supply, ignored second start
    pix_a[0] = 24'hFF0080;
    clear_mon();
    pulse_start();
    repeat (2000) step;
    pulse_start();
    wait_done_a(20000, "f1");
    chk("f1_busy_at_done", busy_a, 1);
    step;
    chk("f1_busy_after_done", busy_a, 0);
    wait_idle_b(12000);
    for (int i = 0; i < 4; i++) exp_px[i] = {pix_a[i], 8'h00};
    check_stream(0, 4, 3, 0, RSTA, "f1_a");
    chk("f1_gaps", gaps[0], 0);
    chk("f1_underrun", ur_a, 0);
    chk("f1_fetches", nlog, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("f1_addr%0d", i), addr_log[i], i);
    exp_px[0] = 32'h01020304;
    check_stream(1, 1, 4, 1, RSTB, "f1_b");
    check_stream(2, 1, 4, 2, RSTC, "f1_c");

    // Frame 2: pixel 2 withheld until underrun, then 500 more cycles
    for (int i = 0; i < 4; i++) pix_a[i] = 24'($urandom);
    data_b = $urandom; data_c = $urandom;
    clear_mon();
    withhold = 1'b1; released = 1'b0;
    pulse_start();
    n = 0;
    while (!ur_a && n < 10000) begin step; n++; end
    chk("f2_underrun_set", ur_a, 1);
    highs = 0;
    repeat (500) begin step; if (do_a) highs++; end
    chk("f2_do_low_in_gap", highs, 0);
    chk("f2_busy_in_gap", busy_a, 1);
    released = 1'b1;
    wait_done_a(20000, "f2");
    step;
    wait_idle_b(12000);
    for (int i = 0; i < 4; i++) exp_px[i] = {pix_a[i], 8'h00};
    check_stream(0, 4, 3, 0, RSTA, "f2_a");
    chk("f2_gaps", gaps[0], 1);
    chk("f2_underrun_sticky", ur_a, 1);
    exp_px[0] = data_b;
    check_stream(1, 1, 4, 1, RSTB, "f2_b");
    exp_px[0] = data_c;
    check_stream(2, 1, 4, 2, RSTC, "f2_c");
    withhold = 1'b0;

    // Frame 3: start clears underrun, then reset lands in a high phase
    pulse_start();
    chk("f3_underrun_cleared", ur_a, 0);
    chk("f3_busy", busy_a, 1);
    repeat (300) step;
    n = 0;
    while (!do_a && n < 200) begin step; n++; end
    chk("f3_found_high", do_a, 1);
    rst = 1'b1;
    #1;
    chk("f3_reset_do", do_a, 0);
    chk("f3_reset_busy", busy_a, 0);
    chk("f3_reset_ready", ready_a, 0);
    repeat (3) step;
    rst = 1'b0;
    step;

    // Frame 4: full frame from LED 0 after reset
    for (int i = 0; i < 4; i++) pix_a[i] = 24'($urandom);
    clear_mon();
    pulse_start();
    wait_done_a(20000, "f4");
    step;
    wait_idle_b(12000);
    for (int i = 0; i < 4; i++) exp_px[i] = {pix_a[i], 8'h00};
    check_stream(0, 4, 3, 0, RSTA, "f4_a");
    chk("f4_fetches", nlog, 4);
    chk("f4_first_addr", addr_log[0], 0);
    chk("one_led_addr_zero", addr_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
